// File: rtl/pg_seq_pkg.sv
// Shared types and constants for the bank power-gating sequencer.
package pg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISO     = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pg_rr_pick.sv
// Round-robin picker: first pending bank at or after rr_ptr, wrapping around.
module pg_rr_pick #(
  parameter int NUM_BANKS = 4,
  parameter int IDX_W     = $clog2(NUM_BANKS)
) (
  input  logic [NUM_BANKS-1:0] pending,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  int cand_s;

  // Scan offsets from rr_ptr upward; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    idx    = rr_ptr;
    cand_s = 0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      cand_s = (int'(rr_ptr) + k) % NUM_BANKS;
      if (!valid && pending[cand_s]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand_s);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/pg_bank_sequencer.sv
// Sequences one bank at a time through isolate / switch / settle / release,
// granting pending power-up and power-down requests round-robin.
module pg_bank_sequencer
  import pg_seq_pkg::*;
#(
  parameter int NUM_BANKS     = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_BANKS-1:0]         req_on,
  input  logic [NUM_BANKS-1:0]         req_off,
  output logic [NUM_BANKS-1:0]         pg_en,
  output logic [NUM_BANKS-1:0]         iso_en,
  output logic [NUM_BANKS-1:0]         bank_ready,
  output logic                         busy,
  output logic [$clog2(NUM_BANKS)-1:0] cur_bank,
  output logic                         cur_dir
);

  localparam int IDX_W = $clog2(NUM_BANKS);

  state_t               state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     rr_ptr_r, rr_ptr_s;
  logic [NUM_BANKS-1:0] pg_en_r, pg_en_s;
  logic [NUM_BANKS-1:0] iso_en_r, iso_en_s;
  logic [NUM_BANKS-1:0] bank_ready_r, bank_ready_s;
  logic                 busy_r, busy_s;
  logic [IDX_W-1:0]     cur_bank_r, cur_bank_s;
  logic                 cur_dir_r, cur_dir_s;

  logic [NUM_BANKS-1:0] pending_s;
  logic                 pick_valid_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_dir_s;

  // Conflicting requests and requests for the current state are not pending.
  assign pending_s = (req_on & ~req_off & ~pg_en_r) | (req_off & ~req_on & pg_en_r);

  pg_rr_pick #(
    .NUM_BANKS (NUM_BANKS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .pending (pending_s),
    .rr_ptr  (rr_ptr_r),
    .valid   (pick_valid_s),
    .idx     (pick_idx_s)
  );

  // Next-state and next-output logic for the sequencing FSM.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    rr_ptr_s     = rr_ptr_r;
    pg_en_s      = pg_en_r;
    iso_en_s     = iso_en_r;
    bank_ready_s = bank_ready_r;
    busy_s       = busy_r;
    cur_bank_s   = cur_bank_r;
    cur_dir_s    = cur_dir_r;
    // A pending bank that is currently off is being powered up.
    pick_dir_s   = pg_en_r[pick_idx_s] ? DIR_DOWN : DIR_UP;

    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          cur_bank_s = pick_idx_s;
          cur_dir_s  = pick_dir_s;
          busy_s     = 1'b1;
          rr_ptr_s   = (pick_idx_s == IDX_W'(NUM_BANKS - 1)) ? {IDX_W{1'b0}}
                                                             : pick_idx_s + IDX_W'(1);
          state_s    = (pick_dir_s == DIR_UP) ? SWITCH : ISO;
        end else begin
          state_s = IDLE;
        end
      end
      ISO: begin
        bank_ready_s[cur_bank_r] = 1'b0;
        iso_en_s[cur_bank_r]     = 1'b1;
        state_s                  = SWITCH;
      end
      SWITCH: begin
        pg_en_s[cur_bank_r] = cur_dir_r;
        cnt_s               = CNT_W'(SETTLE_CYCLES - 1);
        state_s             = SETTLE;
      end
      SETTLE: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          if (cur_dir_r == DIR_UP) begin
            state_s = RELEASE;
          end else begin
            busy_s  = 1'b0;
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      RELEASE: begin
        iso_en_s[cur_bank_r]     = 1'b0;
        bank_ready_s[cur_bank_r] = 1'b1;
        busy_s                   = 1'b0;
        state_s                  = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves every bank off and isolated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      pg_en_r      <= {NUM_BANKS{1'b0}};
      iso_en_r     <= {NUM_BANKS{1'b1}};
      bank_ready_r <= {NUM_BANKS{1'b0}};
      busy_r       <= 1'b0;
      cur_bank_r   <= {IDX_W{1'b0}};
      cur_dir_r    <= DIR_DOWN;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      rr_ptr_r     <= rr_ptr_s;
      pg_en_r      <= pg_en_s;
      iso_en_r     <= iso_en_s;
      bank_ready_r <= bank_ready_s;
      busy_r       <= busy_s;
      cur_bank_r   <= cur_bank_s;
      cur_dir_r    <= cur_dir_s;
    end
  end

  assign pg_en      = pg_en_r;
  assign iso_en     = iso_en_r;
  assign bank_ready = bank_ready_r;
  assign busy       = busy_r;
  assign cur_bank   = cur_bank_r;
  assign cur_dir    = cur_dir_r;

endmodule

// File: tb/tb_pg_bank_sequencer.sv
// Directed bench: vector table for single-bank up/down flows plus hand-written
// sequences for round-robin ordering and reset during a sequence.
module tb_pg_bank_sequencer;

  logic       clk;
  logic       rst;
  logic [3:0] req_on;
  logic [3:0] req_off;
  logic [3:0] pg_en;
  logic [3:0] iso_en;
  logic [3:0] bank_ready;
  logic       busy;
  logic [1:0] cur_bank;
  logic       cur_dir;

  int total;
  int passed;

  typedef struct {
    logic [3:0] on;
    logic [3:0] off;
    int         waits;
    logic [3:0] pg;
    logic [3:0] iso;
    logic [3:0] rdy;
    logic       bsy;
    logic [1:0] bank;
    logic       dir;
    string      name;
  } vec_t;

  vec_t vecs[$];

  pg_bank_sequencer #(
    .NUM_BANKS     (4),
    .SETTLE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_on     (req_on),
    .req_off    (req_off),
    .pg_en      (pg_en),
    .iso_en     (iso_en),
    .bank_ready (bank_ready),
    .busy       (busy),
    .cur_bank   (cur_bank),
    .cur_dir    (cur_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic add(input logic [3:0] on, input logic [3:0] off, input int w,
                     input logic [3:0] pg, input logic [3:0] iso, input logic [3:0] rdy,
                     input logic bsy, input logic [1:0] bank, input logic dir, input string nm);
    vec_t v;
    v.on = on; v.off = off; v.waits = w; v.pg = pg; v.iso = iso; v.rdy = rdy;
    v.bsy = bsy; v.bank = bank; v.dir = dir; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [3:0] on);
    @(negedge clk);
    rst     = 1'b1;
    req_on  = on;
    req_off = 4'b0000;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    rst     = 1'b1;
    req_on  = 4'b0000;
    req_off = 4'b0000;
    step(3);
    rst = 1'b0;

    //  on       off      wait pg       iso      rdy      bsy   bank   dir
    add(4'b0000, 4'b0000, 20, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd0, 1'b0, "idle_after_reset");
    add(4'b0100, 4'b0000, 1,  4'b0000, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b1, "up_grant");
    add(4'b0100, 4'b0000, 1,  4'b0100, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b1, "up_switch");
    add(4'b0100, 4'b0000, 8,  4'b0100, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b1, "up_settle_end");
    add(4'b0100, 4'b0000, 1,  4'b0100, 4'b1011, 4'b0100, 1'b0, 2'd2, 1'b1, "up_release");
    add(4'b0100, 4'b0000, 12, 4'b0100, 4'b1011, 4'b0100, 1'b0, 2'd2, 1'b1, "up_no_regrant");
    add(4'b0000, 4'b0100, 1,  4'b0100, 4'b1011, 4'b0100, 1'b1, 2'd2, 1'b0, "dn_grant");
    add(4'b0000, 4'b0100, 1,  4'b0100, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b0, "dn_iso");
    add(4'b0000, 4'b0100, 1,  4'b0000, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b0, "dn_switch");
    add(4'b0000, 4'b0100, 7,  4'b0000, 4'b1111, 4'b0000, 1'b1, 2'd2, 1'b0, "dn_settle");
    add(4'b0000, 4'b0100, 1,  4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd2, 1'b0, "dn_done");
    add(4'b0010, 4'b0010, 15, 4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd2, 1'b0, "conflict_ignored");
    add(4'b0000, 4'b1000, 5,  4'b0000, 4'b1111, 4'b0000, 1'b0, 2'd2, 1'b0, "off_when_off");

    foreach (vecs[i]) begin
      req_on  = vecs[i].on;
      req_off = vecs[i].off;
      step(vecs[i].waits);
      chk({vecs[i].name, "/pg_en"},      32'(pg_en),      32'(vecs[i].pg));
      chk({vecs[i].name, "/iso_en"},     32'(iso_en),     32'(vecs[i].iso));
      chk({vecs[i].name, "/bank_ready"}, 32'(bank_ready), 32'(vecs[i].rdy));
      chk({vecs[i].name, "/busy"},       32'(busy),       32'(vecs[i].bsy));
      chk({vecs[i].name, "/cur_bank"},   32'(cur_bank),   32'(vecs[i].bank));
      chk({vecs[i].name, "/cur_dir"},    32'(cur_dir),    32'(vecs[i].dir));
    end

    // All four requested from reset: grants 0..3, each 11 edges after the last.
    do_reset(4'b1111);
    for (int b = 0; b < 4; b++) begin
      step(1);
      chk($sformatf("rr_grant%0d/busy", b), 32'(busy), 32'd1);
      chk($sformatf("rr_grant%0d/cur_bank", b), 32'(cur_bank), 32'(b));
      chk($sformatf("rr_grant%0d/cur_dir", b), 32'(cur_dir), 32'd1);
      step(10);
      chk($sformatf("rr_done%0d/ready", b), 32'(bank_ready[b]), 32'd1);
      chk($sformatf("rr_done%0d/busy", b), 32'(busy), 32'd0);
    end
    chk("rr_all/bank_ready", 32'(bank_ready), 32'hF);
    chk("rr_all/pg_en", 32'(pg_en), 32'hF);
    chk("rr_all/iso_en", 32'(iso_en), 32'h0);
    step(5);
    chk("rr_all_quiet/busy", 32'(busy), 32'd0);

    // Reset during SETTLE of a bank-3 power-up.
    do_reset(4'b1000);
    step(1);
    chk("midrst_grant/cur_bank", 32'(cur_bank), 32'd3);
    step(4);
    chk("midrst_settle/pg_en", 32'(pg_en), 32'h8);
    chk("midrst_settle/busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_now/pg_en", 32'(pg_en), 32'h0);
    chk("midrst_now/iso_en", 32'(iso_en), 32'hF);
    chk("midrst_now/bank_ready", 32'(bank_ready), 32'h0);
    chk("midrst_now/busy", 32'(busy), 32'd0);
    chk("midrst_now/cur_bank", 32'(cur_bank), 32'd0);
    chk("midrst_now/cur_dir", 32'(cur_dir), 32'd0);
    step(2);
    rst = 1'b0;
    step(1);
    chk("midrst_regrant/busy", 32'(busy), 32'd1);
    chk("midrst_regrant/cur_bank", 32'(cur_bank), 32'd3);
    step(10);
    chk("midrst_regrant/bank_ready", 32'(bank_ready), 32'h8);

    // Pointer sits at 2 after bank 1 comes up; reset must return it to 0.
    do_reset(4'b0010);
    step(11);
    chk("ptr_pre/bank_ready", 32'(bank_ready), 32'h2);
    do_reset(4'b1001);
    step(1);
    chk("ptr_reset/cur_bank", 32'(cur_bank), 32'd0);
    chk("ptr_reset/busy", 32'(busy), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
